// File: rtl/matmul_kstream_core.sv
// matmul_kstream_core: streamed M x K by K x N signed matrix multiply.
// Optional MATMUL_SAT_EN: saturating accumulate plus sticky sat_flag port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, k_len        begin a product of k_len beats (sampled in IDLE)
//   in_valid, in_ready  operand beat handshake
//   a_col, b_row        A[i][k] and B[k][j] for the current beat
//   out_valid, out_ready result handshake
//   c_flat              C[i][j] at [(i*N+j)*ACC_W +: ACC_W]
//   sat_flag            (MATMUL_SAT_EN only) any accumulate clipped
//   busy                state != IDLE
module matmul_kstream_core #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int M      = 2,
   parameter int N      = 2,
   parameter int KMAX_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KMAX_W-1:0]      k_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [M*DATA_W-1:0]    a_col,
   input  logic [N*DATA_W-1:0]    b_row,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [M*N*ACC_W-1:0]   c_flat,
`ifdef MATMUL_SAT_EN
   output logic                   sat_flag,
`endif
   output logic                   busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   // Sum width: one guard bit when saturating so overflow is visible.
`ifdef MATMUL_SAT_EN
   localparam int SW = ACC_W + 1;
`else
   localparam int SW = ACC_W;
`endif

   state_t state_q, state_d;
   logic [KMAX_W-1:0] cnt_q, cnt_d;
   logic [M*N-1:0][ACC_W-1:0] acc_q, acc_d;
`ifdef MATMUL_SAT_EN
   logic sat_q, sat_d;
`endif

   logic beat;
   logic [2*DATA_W-1:0] a_x, b_x, prod;
   logic [SW-1:0] prod_x, acc_x, sum;

   assign beat = (state_q == S_ACCUM) && in_valid;

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
`ifdef MATMUL_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
`ifdef MATMUL_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (k_len == '0) ? S_OUT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (beat && cnt_q == KMAX_W'(1)) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (state_q == S_ACCUM);
      out_valid = (state_q == S_OUT);
      busy      = (state_q != S_IDLE);
   end

   // Accumulator array and beat counter
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      a_x    = '0;
      b_x    = '0;
      prod   = '0;
      prod_x = '0;
      acc_x  = '0;
      sum    = '0;
`ifdef MATMUL_SAT_EN
      sat_d  = sat_q;
`endif
      if (state_q == S_IDLE && start) begin
         acc_d = '0;
         cnt_d = k_len;
`ifdef MATMUL_SAT_EN
         sat_d = 1'b0;
`endif
      end else if (beat) begin
         cnt_d = cnt_q - KMAX_W'(1);
         for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
               // Operands widened to the full product width so the
               // low 2*DATA_W bits carry the exact signed product.
               a_x = {{DATA_W{a_col[i*DATA_W+DATA_W-1]}},
                      a_col[i*DATA_W +: DATA_W]};
               b_x = {{DATA_W{b_row[j*DATA_W+DATA_W-1]}},
                      b_row[j*DATA_W +: DATA_W]};
               prod = a_x * b_x;
               prod_x = {{(SW-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`ifdef MATMUL_SAT_EN
               acc_x = {acc_q[i*N+j][ACC_W-1], acc_q[i*N+j]};
               sum = acc_x + prod_x;
               if (sum[SW-1] != sum[SW-2]) begin
                  sat_d = 1'b1;
                  // Guard bit gives the true sign of the sum.
                  acc_d[i*N+j] = sum[SW-1]
                     ? {1'b1, {(ACC_W-1){1'b0}}}
                     : {1'b0, {(ACC_W-1){1'b1}}};
               end else begin
                  acc_d[i*N+j] = sum[ACC_W-1:0];
               end
`else
               acc_x = acc_q[i*N+j];
               sum = acc_x + prod_x;
               acc_d[i*N+j] = sum;
`endif
            end
         end
      end
   end

   assign c_flat = acc_q;
`ifdef MATMUL_SAT_EN
   assign sat_flag = sat_q;
`endif

endmodule

// File: doc/matmul_kstream_core.md
Name: matmul_kstream_core

Overview:
Parametrised successor to the fixed 2x2 matmul_top core. Computes C = A x B for an M x K by K x N product, with M, N and data widths set by parameter and K chosen at run time. Operands arrive one k-slice per beat on a valid/ready stream; an M x N array of signed MACs accumulates them. The result is held under a valid/ready output handshake, so the block can sit behind an AXI-Stream/DMA front end in the accelerator.

Parameters:
DATA_W, 16, signed operand width
ACC_W, 32, signed accumulator/result width (must be >= 2*DATA_W)
M, 2, rows of A and C
N, 2, columns of B and C
KMAX_W, 8, width of k_len; maximum K = 2^KMAX_W-1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin new product; sampled only in IDLE
k_len  in  KMAX_W  number of k-beats; sampled with start
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept an operand beat
a_col  in  M*DATA_W  A[i][k] at bits [i*DATA_W +: DATA_W]
b_row  in  N*DATA_W  B[k][j] at bits [j*DATA_W +: DATA_W]
out_valid  out  1  c_flat holds a complete result
out_ready  in  1  consumer accepts result
c_flat  out  M*N*ACC_W  C[i][j] at bits [(i*N+j)*ACC_W +: ACC_W]
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; accumulators, beat counter and c_flat cleared to 0; in_ready=0, out_valid=0, busy=0. Reset takes effect mid-operation and discards any partial result.
- FSM states:
  - IDLE: in_ready=0, out_valid=0. On start=1: clear all accumulators and latch k_len into the beat counter. If k_len!=0, go to ACCUM. If k_len==0, go to OUT with an all-zero result.
  - ACCUM: in_ready=1. A beat is accepted when in_valid&&in_ready. On each accepted beat, every accumulator does acc[i][j] += sext(a_i*b_j) and the counter decrements. When the last beat is accepted, go to OUT. Cycles with in_valid=0 stall; there is no timeout.
  - OUT: out_valid=1 and c_flat stable; in_ready=0. When out_valid&&out_ready, go to IDLE at the next edge; out_valid is low in that next cycle.
- Latency: out_valid rises the cycle after the final beat is accepted. The minimum start-to-out_valid time is K+1 cycles.
- start outside IDLE is ignored. start in the same cycle as the OUT handshake is also ignored; the next start must arrive in IDLE.
- Arithmetic:
  - Each product is a full 2*DATA_W signed value, sign-extended to ACC_W.
  - The accumulator sum wraps modulo 2^ACC_W (two's complement) unless SAT is enabled.
- c_flat is driven from the accumulators. It changes only in ACCUM and at the start clear, so it holds last-result values in IDLE until the next start.
- in_valid in IDLE or OUT is not consumed. The upstream source must hold the data.

Optional Feature:
Macro MATMUL_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and a sticky output port sat_flag (1 bit) is added. sat_flag is set on any clipped accumulate, cleared on start and rst, and valid with out_valid.
- Undefined: wrap-around arithmetic and no sat_flag port.

Test Plan:
1. M=N=2, k_len=2, beats (a_col,b_row) = ({1,3},{5,6}) then ({2,4},{7,8}) -> out_valid 1 cycle after beat 2; C = {{19,22},{43,50}}.
2. Signed operands, k_len=3, A={{-1,2,-3},{4,-5,6}}, B={{7,-8},{-9,10},{11,-12}} -> C = {{-58,64},{139,-154}}.
3. Backpressure: in_valid toggles 1,0,0,1 and out_ready is held low 5 cycles -> only 2 beats consumed; out_valid and c_flat stay stable until out_ready; then IDLE with busy=0.
4. k_len=0 with start -> OUT the next cycle with C all zero. A start pulse while in OUT is ignored (counter and result unchanged).
5. Overflow, k_len=2, every operand -32768 -> C[0][0] = -2147483648 (wrap) without MATMUL_SAT_EN; 2147483647 and sat_flag=1 with it.
6. rst asserted after 1 of 3 beats -> next cycle: IDLE, c_flat=0, in_ready=0. A fresh test-1 run then produces {{19,22},{43,50}}.
